bram_arbiter: RTL
=================

Name: bram_arbiter

Overview:
- Shares one weight/activation BRAM between two clients: client 0 is the forward-pass fetch and client 1 is the backprop update.
- The BRAM has one registered read port and one write port. The arbiter runs them as two independent round-robin channels.
- Each client gets a read handshake with a tagged 1-cycle response, plus a write handshake.
- Sits directly in front of the BRAM instance. It is the only driver of the BRAM's read and write controls.

Parameters:
- DATA_WIDTH, 32, width of BRAM words and of all client data paths.
- ADDR_WIDTH, 8, width of BRAM and client addresses.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- c0_rreq, c1_rreq  in  1  read request, per client.
- c0_raddr, c1_raddr  in  ADDR_WIDTH  read address, per client.
- c0_rgnt, c1_rgnt  out  1  read grant, combinational; the read is accepted when req&gnt.
- c0_rvalid, c1_rvalid  out  1  read data valid, one cycle after acceptance.
- c0_rdata, c1_rdata  out  DATA_WIDTH  read data; both are driven from bramReadData.
- c0_wreq, c1_wreq  in  1  write request.
- c0_waddr, c1_waddr  in  ADDR_WIDTH  write address.
- c0_wdata, c1_wdata  in  DATA_WIDTH  write data.
- c0_wgnt, c1_wgnt  out  1  write grant, combinational.
- bramReadEnable  out  1  to BRAM readEnable.
- bramReadAddress  out  ADDR_WIDTH  to BRAM.
- bramReadData  in  DATA_WIDTH  from BRAM; registered, 1-cycle latency.
- bramWriteEnable  out  1  to BRAM.
- bramWriteAddress  out  ADDR_WIDTH  to BRAM.
- bramWriteData  out  DATA_WIDTH  to BRAM.

Behaviour:
- Reset (resetn low, takes effect immediately):
  - rd_ptr=0, wr_ptr=0, rvalid_tag=none.
  - Both rvalid outputs 0; all grants 0 while resetn is low.
- Read channel:
  - Grant logic: if exactly one client has rreq, grant it. If both, grant client rd_ptr.
  - Only one rgnt is ever high. bramReadEnable = OR of the grants.
  - bramReadAddress = granted client's raddr, or 0 when idle.
  - Pointer update: on a cycle where both requested, rd_ptr <= the loser's index. Otherwise rd_ptr holds.
  - Response: on acceptance of client k, next cycle ck_rvalid=1 and the other rvalid=0. A single registered tag selects which rvalid fires.
  - Back-to-back acceptances give back-to-back rvalids; full throughput is one read per cycle.
- Write channel: identical structure with its own wr_ptr.
  - bramWriteEnable, bramWriteAddress and bramWriteData follow the granted client; all are 0 when idle.
  - A write completes at the clock edge of acceptance.
- Reads and writes are arbitrated independently. A read by one client and a write by the other may both be granted in the same cycle.
- Same-address read and write in one cycle: the BRAM forwards the write data, so rdata equals the new wdata. The arbiter adds no logic for this.
- Client rules:
  - A requester holds req, address and data stable until granted.
  - Dropping req before grant is legal; nothing is issued.
  - A grant never depends on the other channel.
- Starvation bound: a continuously requesting client is granted within 2 cycles.
- Reset mid-operation: an in-flight read tag is cleared, so no rvalid appears after reset is released. The pointers return to 0.
- Outputs depend combinationally on req inputs. There is no combinational path from rdata to any control output.

Optional Feature:
- Macro: BRAM_ARB_STATS_EN.
- When defined:
  - Adds output ports rd_conflicts and wr_conflicts, each 16 bits.
  - Each is a counter that increments on every cycle in which both clients request that channel.
  - Counters saturate at 16'hFFFF and reset to 0 asynchronously.
- When undefined: the ports and counters are absent, and arbitration behaviour is identical.

Decomposition:
- Shared package holds:
  - CLIENT_FWD=0 and CLIENT_BWD=1 constants.
  - The client-index type (1 bit).
  - The stats counter width constant, 16.
- One natural sub-module: rr_arb2, a two-requester round-robin with pointer register, instantiated twice (read and write channels).
  - Ports: clock, resetn, req[1:0], gnt[1:0].
  - The pointer advances on contention only.

Test Plan:
- Reset then idle: all grants 0, rvalid 0, bramReadEnable=0, bramWriteEnable=0.
- c0 read of addr 0x05 only, BRAM preloaded 0x05=32'hDEADBEEF:
  - c0_rgnt=1 the same cycle.
  - Next cycle c0_rvalid=1 with rdata 32'hDEADBEEF, and c1_rvalid=0.
- Both clients read continuously for 6 cycles, c0 addr 0x01 and c1 addr 0x02:
  - Grants alternate c0,c1,c0,c1,c0,c1.
  - rvalids alternate one cycle later with the matching data.
  - With the stats macro defined, rd_conflicts=6.
- Both clients write the same cycle, c0 0x10←1 and c1 0x11←2, then both read:
  - c0 write lands first and c1 the next cycle.
  - Readback returns 0x10=1 and 0x11=2.
- c1 write 0x20←0xAA while c0 reads 0x20 in the same cycle: both granted, and c0_rvalid next cycle with rdata 0xAA.
- Assert resetn low the cycle after a c1 read is accepted: c1_rvalid never goes high, and after release the pointers are 0 (c0 wins the first contention).

Source files
------------

// File: rtl/bram_arbiter_pkg.sv
// Shared types and constants for the two-client BRAM arbiter.
// Client indices, stats counter width and the read-response tag layout.
package bram_arbiter_pkg;

    typedef logic client_idx_t;

    localparam client_idx_t CLIENT_FWD = 1'b0;
    localparam client_idx_t CLIENT_BWD = 1'b1;

    localparam int STATS_WIDTH = 16;

    // Identifies which client owns the read response arriving next cycle.
    typedef struct packed {
        logic        valid;
        client_idx_t idx;
    } rd_tag_t;

    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/bram_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the winner of the next
// contention and only moves when both requesters are active.
module rr_arb2
    import bram_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    client_idx_t ptr;
    logic        contention;

    assign contention = &req;

    // Grants are held low for the whole time reset is asserted.
    always_comb begin
        gnt = 2'b00;
        if (resetn) begin
            if (contention) begin
                gnt = (ptr == CLIENT_BWD) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr <= CLIENT_FWD;
        end else if (contention) begin
            ptr <= ~ptr;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Arbitrates one BRAM read port and one write port between forward (0) and
// backprop (1) clients. BRAM_ARB_STATS_EN adds saturating contention counters.
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  c0_rreq,
    input  logic                  c1_rreq,
    input  logic [ADDR_WIDTH-1:0] c0_raddr,
    input  logic [ADDR_WIDTH-1:0] c1_raddr,
    output logic                  c0_rgnt,
    output logic                  c1_rgnt,
    output logic                  c0_rvalid,
    output logic                  c1_rvalid,
    output logic [DATA_WIDTH-1:0] c0_rdata,
    output logic [DATA_WIDTH-1:0] c1_rdata,
    input  logic                  c0_wreq,
    input  logic                  c1_wreq,
    input  logic [ADDR_WIDTH-1:0] c0_waddr,
    input  logic [ADDR_WIDTH-1:0] c1_waddr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    output logic                  c0_wgnt,
    output logic                  c1_wgnt,
    output logic                  bramReadEnable,
    output logic [ADDR_WIDTH-1:0] bramReadAddress,
    input  logic [DATA_WIDTH-1:0] bramReadData,
    output logic                  bramWriteEnable,
    output logic [ADDR_WIDTH-1:0] bramWriteAddress,
    output logic [DATA_WIDTH-1:0] bramWriteData
`ifdef BRAM_ARB_STATS_EN
    ,
    output logic [STATS_WIDTH-1:0] rd_conflicts,
    output logic [STATS_WIDTH-1:0] wr_conflicts
`endif
);

    // Handshake: a transfer happens on a rising edge where req && gnt; gnt is
    // combinational from req, and the client holds req/addr/data until granted.
    logic [1:0] rd_gnt;
    logic [1:0] wr_gnt;
    rd_tag_t    rd_tag;

    rr_arb2 u_rd_arb (
        .clock  (clock),
        .resetn (resetn),
        .req    ({c1_rreq, c0_rreq}),
        .gnt    (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clock  (clock),
        .resetn (resetn),
        .req    ({c1_wreq, c0_wreq}),
        .gnt    (wr_gnt)
    );

    assign c0_rgnt = rd_gnt[CLIENT_FWD];
    assign c1_rgnt = rd_gnt[CLIENT_BWD];
    assign c0_wgnt = wr_gnt[CLIENT_FWD];
    assign c1_wgnt = wr_gnt[CLIENT_BWD];

    assign bramReadEnable  = |rd_gnt;
    assign bramWriteEnable = |wr_gnt;

    always_comb begin
        bramReadAddress = '0;
        if (rd_gnt[CLIENT_FWD]) begin
            bramReadAddress = c0_raddr;
        end else if (rd_gnt[CLIENT_BWD]) begin
            bramReadAddress = c1_raddr;
        end
    end

    always_comb begin
        bramWriteAddress = '0;
        bramWriteData    = '0;
        if (wr_gnt[CLIENT_FWD]) begin
            bramWriteAddress = c0_waddr;
            bramWriteData    = c0_wdata;
        end else if (wr_gnt[CLIENT_BWD]) begin
            bramWriteAddress = c1_waddr;
            bramWriteData    = c1_wdata;
        end
    end

    // The tag lines up with the BRAM's one-cycle registered read latency.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_tag <= '0;
        end else begin
            rd_tag.valid <= bramReadEnable;
            rd_tag.idx   <= client_idx_t'(rd_gnt[CLIENT_BWD]);
        end
    end

    assign c0_rvalid = rd_tag.valid && (rd_tag.idx == CLIENT_FWD);
    assign c1_rvalid = rd_tag.valid && (rd_tag.idx == CLIENT_BWD);
    assign c0_rdata  = bramReadData;
    assign c1_rdata  = bramReadData;

`ifdef BRAM_ARB_STATS_EN
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_conflicts <= '0;
            wr_conflicts <= '0;
        end else begin
            if (c0_rreq && c1_rreq) begin
                rd_conflicts <= sat_inc(rd_conflicts);
            end
            if (c0_wreq && c1_wreq) begin
                wr_conflicts <= sat_inc(wr_conflicts);
            end
        end
    end
`endif

endmodule
